// File: rtl/dispatch_pkg.sv
// Shared types and constants for the task dispatcher: FSM states, control-block
// address bit positions and AXI response codes.
package dispatch_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam int PROG_BIT = 7;
    localparam int BUSY_BIT = 8;
    localparam int NODE_LSB = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        PICK,
        WR_REQ,
        WR_RESP,
        GAP
    } dispatch_state_t;

endpackage

// File: rtl/if_axi_light.sv
// Minimal AXI-lite bundle (no prot/cache signals) used between the dispatcher
// and the control block.
interface if_axi_light;
    import dispatch_pkg::*;

    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [3:0]                wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic                      arvalid;
    logic                      arready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/dispatch_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending program offsets;
// head is valid whenever empty is low.
module dispatch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/task_dispatcher.sv
// Queues program offsets and hands each one to the next free processing node
// over AXI-lite. Define TASK_DISPATCHER_STATS_EN to build the dispatched/rejected counters.
module task_dispatcher
    import dispatch_pkg::*;
#(
    parameter int          NUM_NODES  = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] CTRL_BASE  = 32'h8000_0000,
    parameter int          POLL_GAP   = 16
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        push_valid,
    output logic                        push_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   push_offset,
    if_axi_light.master                 m_axi,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err,
    output logic [31:0]                 dispatched,
    output logic [15:0]                 rejected
);

    localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [NODE_W:0]   NUM_NODES_W = (NODE_W+1)'(NUM_NODES);
    localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(POLL_GAP - 1);
    localparam logic [31:0]       BUSY_ADDR   = CTRL_BASE | (32'd1 << BUSY_BIT);
    localparam logic [31:0]       PROG_ADDR   = CTRL_BASE | (32'd1 << PROG_BIT);

    dispatch_state_t state;
    dispatch_state_t next_state;

    logic [NUM_NODES-1:0]      busy;
    logic [NODE_W-1:0]         node;
    logic [NODE_W-1:0]         last_node;
    logic [NODE_W-1:0]         pick_node;
    logic                      pick_found;
    logic [NODE_W:0]           cand;
    logic                      aw_done;
    logic                      w_done;
    logic [GAP_W-1:0]          gap_cnt;
    logic                      push_accept;
    logic                      push_zero;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [AXI_DATA_WIDTH-1:0] fifo_head;

    assign push_ready  = !fifo_full;
    assign push_accept = push_valid && push_ready;
    assign push_zero   = push_accept && (push_offset == '0);

    dispatch_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push_accept && !push_zero),
        .pop   (fifo_pop),
        .din   (push_offset),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Round-robin search starting just after the last node served.
    always_comb begin
        pick_found = 1'b0;
        pick_node  = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_NODES; i++) begin
            cand = {1'b0, last_node} + (NODE_W+1)'(i);
            if (cand >= NUM_NODES_W) begin
                cand = cand - NUM_NODES_W;
            end
            if (!pick_found && !busy[cand[NODE_W-1:0]]) begin
                pick_found = 1'b1;
                pick_node  = cand[NODE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        fifo_pop        = 1'b0;
        m_axi.araddr    = BUSY_ADDR;
        m_axi.arvalid   = 1'b0;
        m_axi.rready    = 1'b0;
        m_axi.awaddr    = PROG_ADDR | (32'(node) << NODE_LSB);
        m_axi.awvalid   = 1'b0;
        m_axi.wdata     = fifo_head;
        m_axi.wstrb     = '1;
        m_axi.wvalid    = 1'b0;
        m_axi.bready    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = RD_REQ;
                end
            end
            RD_REQ: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    next_state = RD_RESP;
                end
            end
            RD_RESP: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) begin
                    next_state = (m_axi.rresp == RESP_OKAY) ? PICK : GAP;
                end
            end
            PICK: begin
                next_state = pick_found ? WR_REQ : GAP;
            end
            WR_REQ: begin
                m_axi.awvalid = !aw_done;
                m_axi.wvalid  = !w_done;
                if ((aw_done || m_axi.awready) && (w_done || m_axi.wready)) begin
                    next_state = WR_RESP;
                end
            end
            WR_RESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    if (m_axi.bresp == RESP_OKAY) begin
                        fifo_pop   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = RD_REQ;
                end
            end
            default: next_state = IDLE;
        endcase
        // Reset must silence the bus in the very cycle it is asserted.
        if (res) begin
            m_axi.arvalid = 1'b0;
            m_axi.rready  = 1'b0;
            m_axi.awvalid = 1'b0;
            m_axi.wvalid  = 1'b0;
            m_axi.bready  = 1'b0;
            fifo_pop      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            busy      <= '0;
            node      <= '0;
            last_node <= NODE_W'(NUM_NODES - 1);
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            gap_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (push_zero) begin
                err <= 1'b1;
            end
            case (state)
                RD_RESP: begin
                    if (m_axi.rvalid) begin
                        if (m_axi.rresp == RESP_OKAY) begin
                            busy <= m_axi.rdata[NUM_NODES-1:0];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PICK: begin
                    node    <= pick_node;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                WR_REQ: begin
                    if (m_axi.awvalid && m_axi.awready) begin
                        aw_done <= 1'b1;
                    end
                    if (m_axi.wvalid && m_axi.wready) begin
                        w_done <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        if (m_axi.bresp == RESP_OKAY) begin
                            last_node <= node;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TASK_DISPATCHER_STATS_EN
    always_ff @(posedge clk) begin
        if (res) begin
            dispatched <= '0;
            rejected   <= '0;
        end else begin
            if (fifo_pop) begin
                dispatched <= dispatched + 1'b1;
            end
            if (push_zero) begin
                rejected <= rejected + 1'b1;
            end
        end
    end
`else
    assign dispatched = '0;
    assign rejected   = '0;
`endif

endmodule
